// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory responder: FSM states, counter sizing, pipe ids.
package dmem_pkg;

    localparam int STATE_W = 2;

    typedef enum logic [STATE_W-1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } dmem_state_e;

    localparam int WAIT_MIN = 1;
    localparam int WAIT_MAX = 15;
    localparam int CNT_W    = 4;

    localparam logic PIPE1 = 1'b0;
    localparam logic PIPE2 = 1'b1;

endpackage

// File: rtl/dmem_sram_array.sv
// Single-port synchronous word array: write or registered read on an enabled edge, one-cycle read latency.
// No backpressure; contents are never reset.
module dmem_sram_array #(
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              i_en,
    input  logic              i_we,
    input  logic [IDX_W-1:0]  i_idx,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH_WORDS];
    logic [DATA_W-1:0] r_rdata;

    always_ff @(posedge clk) begin
        if (i_en) begin
            if (i_we) begin
                r_mem[i_idx] <= i_wdata;
            end else begin
                r_rdata <= r_mem[i_idx];
            end
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/shared_dmem_responder.sv
// Serves one pipe's load/store at a time; mem_ready pulses WAIT_CYCLES cycles after the request is sampled,
// then one forced idle cycle. Requests are latched, not aborted. Optional counters under DMEM_STATS_EN.
module shared_dmem_responder
    import dmem_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 3
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              mem_user,
    input  logic              memtoreg_1,
    input  logic              memwrite_1,
    input  logic [ADDR_W-1:0] addr_1,
    input  logic [DATA_W-1:0] wdata_1,
    input  logic              memtoreg_2,
    input  logic              memwrite_2,
    input  logic [ADDR_W-1:0] addr_2,
    input  logic [DATA_W-1:0] wdata_2,
    output logic              mem_ready,
    output logic              served_port,
    output logic [DATA_W-1:0] rdata_1,
    output logic [DATA_W-1:0] rdata_2,
    output logic              busy
`ifdef DMEM_STATS_EN
    ,
    output logic [31:0]       stat_acc_1,
    output logic [31:0]       stat_acc_2,
    output logic [31:0]       stat_contend
`endif
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    dmem_state_e       r_state;
    dmem_state_e       w_state_nxt;
    logic [CNT_W-1:0]  r_cnt;
    logic              r_port;
    logic              r_we;
    logic [IDX_W-1:0]  r_idx;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata_1;
    logic [DATA_W-1:0] r_rdata_2;

    logic              w_req_1;
    logic              w_req_2;
    logic              w_any_req;
    logic              w_sel;
    logic              w_sel_we;
    logic [IDX_W-1:0]  w_sel_idx;
    logic [DATA_W-1:0] w_sel_wdata;
    logic              w_commit;
    logic              w_load_done;
    logic [DATA_W-1:0] w_sram_q;
    logic              w_unused;

    assign w_req_1   = memtoreg_1 | memwrite_1;
    assign w_req_2   = memtoreg_2 | memwrite_2;
    assign w_any_req = w_req_1 | w_req_2;

    // Preferred port first, otherwise whichever port is asking.
    assign w_sel       = mem_user ? (w_req_2 ? PIPE2 : PIPE1) : (w_req_1 ? PIPE1 : PIPE2);
    assign w_sel_we    = (w_sel == PIPE2) ? memwrite_2 : memwrite_1;
    assign w_sel_idx   = (w_sel == PIPE2) ? addr_2[IDX_W+1:2] : addr_1[IDX_W+1:2];
    assign w_sel_wdata = (w_sel == PIPE2) ? wdata_2 : wdata_1;

    assign w_unused = ^{addr_1[ADDR_W-1:IDX_W+2], addr_1[1:0],
                        addr_2[ADDR_W-1:IDX_W+2], addr_2[1:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_any_req) w_state_nxt = ACCESS;
            ACCESS:  if (r_cnt == '0) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // The reset gate keeps a store from landing on the same edge that aborts it.
    assign w_commit    = (r_state == ACCESS) && (r_cnt == '0) && !reset;
    assign w_load_done = (r_state == DONE) && !r_we;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt     <= '0;
            r_port    <= PIPE1;
            r_we      <= 1'b0;
            r_idx     <= '0;
            r_wdata   <= '0;
            r_rdata_1 <= '0;
            r_rdata_2 <= '0;
        end else begin
            if (r_state == IDLE && w_any_req) begin
                r_cnt   <= CNT_W'(WAIT_CYCLES - 1);
                r_port  <= w_sel;
                r_we    <= w_sel_we;
                r_idx   <= w_sel_idx;
                r_wdata <= w_sel_wdata;
            end else if (r_state == ACCESS && r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end
            if (w_load_done && r_port == PIPE1) r_rdata_1 <= w_sram_q;
            if (w_load_done && r_port == PIPE2) r_rdata_2 <= w_sram_q;
        end
    end

    dmem_sram_array #(
        .DATA_W      (DATA_W),
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_sram (
        .clk     (clk),
        .i_en    (w_commit),
        .i_we    (r_we),
        .i_idx   (r_idx),
        .i_wdata (r_wdata),
        .o_rdata (w_sram_q)
    );

    // Read data arrives from the array during DONE; bypass it so rdata is valid with mem_ready.
    assign rdata_1     = (w_load_done && r_port == PIPE1) ? w_sram_q : r_rdata_1;
    assign rdata_2     = (w_load_done && r_port == PIPE2) ? w_sram_q : r_rdata_2;
    assign mem_ready   = (r_state == DONE);
    assign busy        = (r_state != IDLE);
    assign served_port = r_port;

`ifdef DMEM_STATS_EN
    logic [31:0] r_stat_acc_1;
    logic [31:0] r_stat_acc_2;
    logic [31:0] r_stat_contend;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_stat_acc_1   <= '0;
            r_stat_acc_2   <= '0;
            r_stat_contend <= '0;
        end else begin
            if (r_state == DONE && r_port == PIPE1 && r_stat_acc_1 != '1)
                r_stat_acc_1 <= r_stat_acc_1 + 1'b1;
            if (r_state == DONE && r_port == PIPE2 && r_stat_acc_2 != '1)
                r_stat_acc_2 <= r_stat_acc_2 + 1'b1;
            if (r_state == IDLE && w_req_1 && w_req_2 && r_stat_contend != '1)
                r_stat_contend <= r_stat_contend + 1'b1;
        end
    end

    assign stat_acc_1   = r_stat_acc_1;
    assign stat_acc_2   = r_stat_acc_2;
    assign stat_contend = r_stat_contend;
`endif

endmodule

// File: tb/tb_shared_dmem_responder.sv
// Randomized bench for shared_dmem_responder against a transaction-level memory model.
module tb_shared_dmem_responder;

    localparam int AW    = 32;
    localparam int DW    = 32;
    localparam int DEPTH = 64;
    localparam int W     = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic          mem_user;
    logic          memtoreg_1, memwrite_1, memtoreg_2, memwrite_2;
    logic [AW-1:0] addr_1, addr_2;
    logic [DW-1:0] wdata_1, wdata_2;
    logic          mem_ready, served_port, busy;
    logic [DW-1:0] rdata_1, rdata_2;
`ifdef DMEM_STATS_EN
    logic [31:0]   stat_acc_1, stat_acc_2, stat_contend;
`endif

    always #5 clk = ~clk;

    shared_dmem_responder #(
        .ADDR_W      (AW),
        .DATA_W      (DW),
        .DEPTH_WORDS (DEPTH),
        .WAIT_CYCLES (W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_user    (mem_user),
        .memtoreg_1  (memtoreg_1),
        .memwrite_1  (memwrite_1),
        .addr_1      (addr_1),
        .wdata_1     (wdata_1),
        .memtoreg_2  (memtoreg_2),
        .memwrite_2  (memwrite_2),
        .addr_2      (addr_2),
        .wdata_2     (wdata_2),
        .mem_ready   (mem_ready),
        .served_port (served_port),
        .rdata_1     (rdata_1),
        .rdata_2     (rdata_2),
        .busy        (busy)
`ifdef DMEM_STATS_EN
        ,
        .stat_acc_1   (stat_acc_1),
        .stat_acc_2   (stat_acc_2),
        .stat_contend (stat_contend)
`endif
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: word array, last load value per pipe, access/contention counts.
    logic [31:0] m_mem [DEPTH];
    logic [31:0] m_rd  [2];
    int          m_acc [2];
    int          m_cont;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int widx(input logic [31:0] a);
        return int'((a >> 2) % DEPTH);
    endfunction

    task automatic drive_idle();
        memtoreg_1 = 1'b0; memwrite_1 = 1'b0; addr_1 = '0; wdata_1 = '0;
        memtoreg_2 = 1'b0; memwrite_2 = 1'b0; addr_2 = '0; wdata_2 = '0;
    endtask

    // Called and returns at a negedge. hold = cycles after sampling before the pipes drop requests.
    task automatic txn(input bit mt1, input bit mw1, input logic [31:0] a1, input logic [31:0] d1,
                       input bit mt2, input bit mw2, input logic [31:0] a2, input logic [31:0] d2,
                       input bit mu, input int hold);
        bit          r1, r2, sel, wr;
        int          idx;
        logic [31:0] wd;
        r1 = mt1 | mw1;
        r2 = mt2 | mw2;
        mem_user   = mu;
        memtoreg_1 = mt1; memwrite_1 = mw1; addr_1 = a1; wdata_1 = d1;
        memtoreg_2 = mt2; memwrite_2 = mw2; addr_2 = a2; wdata_2 = d2;
        if (!r1 && !r2) begin
            @(posedge clk);
            @(negedge clk);
            check("idle_ready", mem_ready, 0);
            check("idle_busy", busy, 0);
            return;
        end
        if (mu) sel = r2 ? 1'b1 : 1'b0;
        else    sel = r1 ? 1'b0 : 1'b1;
        wr  = sel ? mw2 : mw1;
        idx = widx(sel ? a2 : a1);
        wd  = sel ? d2 : d1;
        if (r1 && r2) m_cont++;
        @(posedge clk);
        for (int k = 0; k <= W; k++) begin
            @(negedge clk);
            check("ready", mem_ready, (k == W) ? 1 : 0);
            check("busy", busy, 1);
            check("served", served_port, sel);
            if (k == W) begin
                if (wr) m_mem[idx] = wd;
                else    m_rd[sel]  = m_mem[idx];
                m_acc[sel]++;
                check("rdata_1", rdata_1, m_rd[0]);
                check("rdata_2", rdata_2, m_rd[1]);
            end
            if (k + 1 >= hold) drive_idle();
        end
        @(negedge clk);
        check("gap_ready", mem_ready, 0);
        check("gap_busy", busy, 0);
        check("gap_rdata_1", rdata_1, m_rd[0]);
        check("gap_rdata_2", rdata_2, m_rd[1]);
    endtask

    task automatic check_stats();
`ifdef DMEM_STATS_EN
        check("stat_acc_1", stat_acc_1, m_acc[0]);
        check("stat_acc_2", stat_acc_2, m_acc[1]);
        check("stat_contend", stat_contend, m_cont);
`endif
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"}, mem_ready, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_served"}, served_port, 0);
        check({tag, "_rdata_1"}, rdata_1, 0);
        check({tag, "_rdata_2"}, rdata_2, 0);
    endtask

    task automatic model_reset();
        m_rd[0] = '0; m_rd[1] = '0;
        m_acc[0] = 0; m_acc[1] = 0;
        m_cont = 0;
    endtask

    initial begin
        logic [31:0] ra, rb, da, db, keep_addr, old_word;
        bit          b1, b2, b3, b4;

        reset    = 1'b1;
        mem_user = 1'b0;
        drive_idle();
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("rst");
        check_stats();
        reset = 1'b0;

        // Fill every word so later loads have a known value.
        for (int i = 0; i < DEPTH; i++) begin
            da = $urandom;
            b1 = 1'($urandom_range(0, 1));
            if (b1) txn(0, 0, 0, 0, 0, 1, 32'(i * 4), da, 1'($urandom_range(0, 1)), $urandom_range(1, W + 1));
            else    txn(0, 1, 32'(i * 4), da, 0, 0, 0, 0, 1'($urandom_range(0, 1)), $urandom_range(1, W + 1));
        end
        model_reset();
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Directed: load after store on pipe 1, store/load with ignored low bits on pipe 2.
        txn(0, 1, 32'h40, 32'hDEADBEEF, 0, 0, 0, 0, 0, W + 1);
        txn(1, 0, 32'h40, 0, 0, 0, 0, 0, 0, W + 1);
        check("dir_deadbeef", rdata_1, 32'hDEADBEEF);
        txn(0, 0, 0, 0, 0, 1, 32'h100, 32'h12345678, 1, W + 1);
        txn(0, 0, 0, 0, 1, 0, 32'h102, 0, 1, W + 1);
        check("dir_12345678", rdata_2, 32'h12345678);
        // Contention then preference flip; fallback store; early drop of request.
        txn(1, 0, 32'h44, 0, 1, 0, 32'h10C, 0, 0, W + 1);
        txn(1, 0, 32'h44, 0, 1, 0, 32'h10C, 0, 1, W + 1);
        txn(0, 0, 0, 0, 0, 1, 32'h20, 32'hA5A5_0001, 0, W + 1);
        txn(0, 1, 32'h24, 32'hCAFE_F00D, 0, 0, 0, 0, 0, 1);
        txn(0, 0, 0, 0, 1, 0, 32'h24, 0, 0, 1);
        check("dir_flush", rdata_2, 32'hCAFE_F00D);
        check_stats();

        // Reset while a store is in ACCESS: no pulse, store dropped.
        keep_addr = 32'h34;
        old_word  = m_mem[widx(keep_addr)];
        mem_user  = 1'b0;
        memwrite_1 = 1'b1; addr_1 = keep_addr; wdata_1 = ~old_word;
        @(posedge clk);
        @(negedge clk);
        check("pre_rst_busy", busy, 1);
        reset = 1'b1;
        drive_idle();
        @(posedge clk);
        @(negedge clk);
        check_reset_outputs("midrst");
        reset = 1'b0;
        model_reset();
        check_stats();
        for (int k = 0; k < W + 2; k++) begin
            @(negedge clk);
            check("post_rst_ready", mem_ready, 0);
        end
        txn(1, 0, keep_addr, 0, 0, 0, 0, 0, 0, W + 1);
        check("rst_store_dropped", rdata_1, old_word);

        // Random traffic: request mixes, wrapping addresses, random hold lengths.
        for (int n = 0; n < 200; n++) begin
            ra = $urandom; rb = $urandom; da = $urandom; db = $urandom;
            b1 = 1'($urandom_range(0, 1)); b2 = 1'($urandom_range(0, 1));
            b3 = 1'($urandom_range(0, 1)); b4 = 1'($urandom_range(0, 1));
            txn(b1, b2, ra, da, b3, b4, rb, db, 1'($urandom_range(0, 1)), $urandom_range(1, W + 1));
        end
        check_stats();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/shared_dmem_responder.md
Name: shared_dmem_responder

Overview:
- Memory-side responder for the dual-issue pipeline's shared data memory. It serves load/store requests from the M stage of pipe 1 and pipe 2, one at a time.
- The hazard unit's mem_user select picks which pipe is served. The block answers with a one-cycle mem_ready pulse after a programmable number of wait states.
- It owns the data-memory array. It is the responder half of the MemReady / MemoryUser handshake that the hazard unit uses to run its memory-stall FSM.

Parameters:
- ADDR_W, 32, byte-address width.
- DATA_W, 32, data word width.
- DEPTH_WORDS, 1024, number of words in the array; power of two.
- WAIT_CYCLES, 3, ACCESS-state cycles per request; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on posedge.
- reset  in  1  reset, synchronous, active-high.
- mem_user  in  1  preferred port: 0 = pipe 1, 1 = pipe 2.
- memtoreg_1  in  1  pipe 1 load request.
- memwrite_1  in  1  pipe 1 store request.
- addr_1  in  ADDR_W  pipe 1 byte address.
- wdata_1  in  DATA_W  pipe 1 store data.
- memtoreg_2, memwrite_2, addr_2, wdata_2  in  1/1/ADDR_W/DATA_W  same signals for pipe 2.
- mem_ready  out  1  one-cycle completion pulse.
- served_port  out  1  port of the current or last-completed access.
- rdata_1  out  DATA_W  pipe 1 load data.
- rdata_2  out  DATA_W  pipe 2 load data.
- busy  out  1  high while the FSM is not in IDLE.

Behaviour:
- Reset: state IDLE; mem_ready=0, busy=0, served_port=0, rdata_1=rdata_2=0. Array contents are not reset.
- Request on a port = memtoreg_x | memwrite_x. If both are set, it is treated as a store.
- FSM states: IDLE, ACCESS, DONE.
- IDLE, choosing a port:
  - If the mem_user port has a request, select it.
  - Otherwise, if the other port has a request, select it (fallback; this prevents deadlock when only one pipe accesses memory).
  - Otherwise, stay in IDLE.
- IDLE -> ACCESS on selection. Latch port, word index addr[log2(DEPTH_WORDS)+1:2], write flag and wdata. Load the wait counter with WAIT_CYCLES-1.
- ACCESS:
  - Counter decrements every cycle.
  - When the counter is 0: go to DONE, commit a store to the array on that edge, and register read data for a load into rdata of the served port.
- DONE:
  - mem_ready=1 for exactly this one cycle; rdata is valid.
  - Next state is always IDLE. This gives one guaranteed idle cycle so a request still held by a stalled stage is never re-issued.
- Latency: request sampled at edge E0 → mem_ready is high between edges E0+WAIT_CYCLES and E0+WAIT_CYCLES+1. Minimum spacing between ready pulses is WAIT_CYCLES+2 cycles.
- Latched request: inputs are ignored during ACCESS and DONE. Deassertion or flush of the request mid-access does not abort it; the store still commits and the pulse still occurs.
- mem_user may change freely during ACCESS; it is only sampled in IDLE.
- rdata_x holds its value until the next load served on port x. Stores never modify rdata.
- Address rules: the low two address bits are ignored. Addresses beyond the array wrap modulo DEPTH_WORDS.
- Reset mid-operation: return to IDLE immediately. A store not yet committed is dropped. No mem_ready pulse.
- busy = (state != IDLE). served_port updates on the IDLE->ACCESS edge.

Optional Feature:
- Macro DMEM_STATS_EN.
- Defined: adds outputs
  - stat_acc_1 [31:0]: accesses completed on pipe 1.
  - stat_acc_2 [31:0]: accesses completed on pipe 2.
  - stat_contend [31:0]: cycles in IDLE with both ports requesting.
  - All three saturate at max, are cleared by reset, and increment on DONE / on contention.
- Undefined: these ports and counters do not exist. Behaviour is otherwise identical.

Decomposition:
- Package dmem_pkg: state enum (IDLE/ACCESS/DONE), the 2-bit state width, WAIT_CYCLES legal-range constants, and the port-id constants PIPE1=0, PIPE2=1.
- One sub-module, dmem_sram_array: single-port synchronous array with write enable and registered read, DEPTH_WORDS x DATA_W. The top block holds the FSM, wait counter, arbitration and stats.

Test Plan:
- Single load, pipe 1: WAIT_CYCLES=3, store 0xDEADBEEF @0x40 beforehand, then memtoreg_1=1 addr_1=0x40 before E0 → mem_ready high only between E3 and E4, rdata_1=0xDEADBEEF, rdata_2 unchanged.
- Store then load, pipe 2: memwrite_2 addr 0x100 wdata 0x12345678, then memtoreg_2 addr 0x102 → second access returns 0x12345678 (low bits ignored); pulses 5 cycles apart minimum.
- Contention: both ports request with mem_user=0 → served_port=0 first. After the pulse, set mem_user=1 → pipe 2 served; two pulses total, correct rdata per port.
- Fallback: mem_user=0, only memwrite_2 set → served_port=1, write committed, one pulse.
- Mid-access flush and reset: deassert the request one cycle after E0 → the pulse still occurs and the store commits. Then issue a fresh store and assert reset in ACCESS before the commit edge → no pulse, memory unchanged, outputs at reset values.
- DMEM_STATS_EN: 3 pipe-1 and 2 pipe-2 accesses with 2 contention cycles → stat_acc_1=3, stat_acc_2=2, stat_contend=2.
